// File: rtl/am_modulator_pipe.sv
// Pipelined AM modulator o = c*(1 + m*b): valid/ready flow control, saturating
// fixed-point datapath and a slew-limited modulation index to avoid clicks.
module am_modulator_pipe #(
  parameter int unsigned   DW        = 12,
  parameter int unsigned   MW        = 16,
  parameter logic [MW-1:0] RAMP_STEP = MW'(16'h0100),
  parameter logic [DW-1:0] DIS_VALUE = {1'b0, {(DW-1){1'b1}}}
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [DW-1:0] i_carrier,
  input  logic [DW-1:0] i_baseband,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [MW-1:0] i_mod_index,
  input  logic          i_enable,
  output logic [DW-1:0] o_amSignal,
  output logic          o_valid,
  input  logic          i_ready,
  output logic          o_ramp_busy
);
  localparam int unsigned P1W = MW + DW + 1;
  localparam int unsigned P2W = 2 * DW;
  localparam int unsigned SW  = 2 * DW + 1;

  localparam logic [DW-1:0] D_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0] D_MIN = {1'b1, {(DW-1){1'b0}}};
  localparam logic signed [P1W-1:0] S1_MAX = {{(P1W-DW){1'b0}}, D_MAX};
  localparam logic signed [P1W-1:0] S1_MIN = {{(P1W-DW){1'b1}}, D_MIN};
  localparam logic signed [SW-1:0]  S3_MAX = {{(SW-DW){1'b0}}, D_MAX};
  localparam logic signed [SW-1:0]  S3_MIN = {{(SW-DW){1'b1}}, D_MIN};
  localparam logic signed [SW-1:0]  RND    = {{(SW-DW){1'b0}}, 1'b1, {(DW-1){1'b0}}};

  logic                  ce;
  logic                  xfer;
  logic [MW-1:0]         tgt;
  logic [MW-1:0]         m_cur;
  logic [MW-1:0]         m_next;
  logic                  dis;
  logic signed [P1W-1:0] p1;
  logic signed [P1W-1:0] p1_sh;
  logic [DW-1:0]         s1;
  logic signed [P2W-1:0] p2;
  logic signed [SW-1:0]  c_ext;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  rnd;
  logic [DW-1:0]         res;

  logic                  v1;
  logic                  v2;
  logic                  dis1;
  logic                  dis2;
  logic signed [DW-1:0]  c1;
  logic signed [DW-1:0]  s1_q;
  logic signed [P2W-1:0] p2_q;
  logic signed [SW-1:0]  c_ext_q;

  assign ce      = !o_valid || i_ready;
  assign o_ready = ce;
  assign xfer    = i_valid && ce;
  assign tgt     = i_enable ? i_mod_index : '0;
  assign dis     = !i_enable && (m_cur == '0);

  // Index slews toward its target without overshoot; zero step means jump.
  always_comb begin
    m_next = tgt;
    if (RAMP_STEP != '0) begin
      if (tgt > m_cur) begin
        if (tgt - m_cur > RAMP_STEP) m_next = m_cur + RAMP_STEP;
      end else if (m_cur - tgt > RAMP_STEP) begin
        m_next = m_cur - RAMP_STEP;
      end
    end
  end

  // Stage 1: m*b rescaled to Q1.(DW-1); indices above 1.0 can overflow.
  always_comb begin
    p1    = P1W'($signed({1'b0, m_cur})) * P1W'($signed(i_baseband));
    p1_sh = p1 >>> (MW - 1);
    if (p1_sh > S1_MAX)      s1 = D_MAX;
    else if (p1_sh < S1_MIN) s1 = D_MIN;
    else                     s1 = p1_sh[DW-1:0];
  end

  // Stage 2: c*s1 and the carrier aligned to the same binary point.
  always_comb begin
    p2    = P2W'(c1) * P2W'(s1_q);
    c_ext = SW'(c1) <<< (DW - 1);
  end

  // Stage 3: round half up into Q3.(DW-3), then saturate.
  always_comb begin
    sum = SW'(p2_q) + c_ext_q;
    rnd = (sum + RND) >>> DW;
    if (rnd > S3_MAX)      res = D_MAX;
    else if (rnd < S3_MIN) res = D_MIN;
    else                   res = rnd[DW-1:0];
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      m_cur       <= '0;
      o_ramp_busy <= 1'b0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      o_valid     <= 1'b0;
      dis1        <= 1'b0;
      dis2        <= 1'b0;
      c1          <= '0;
      s1_q        <= '0;
      p2_q        <= '0;
      c_ext_q     <= '0;
      o_amSignal  <= '0;
    end else begin
      if (xfer) m_cur <= m_next;
      o_ramp_busy <= (xfer ? m_next : m_cur) != tgt;
      if (ce) begin
        v1      <= i_valid;
        v2      <= v1;
        o_valid <= v2;
        if (xfer) begin
          c1   <= i_carrier;
          s1_q <= s1;
          dis1 <= dis;
        end
        if (v1) begin
          p2_q    <= p2;
          c_ext_q <= c_ext;
          dis2    <= dis1;
        end
        if (v2) o_amSignal <= dis2 ? DIS_VALUE : res;
      end
    end
  end
endmodule

// File: tb/tb_am_modulator_pipe.sv
// Bench for am_modulator_pipe: a jump-index and a ramped-index instance share
// stimulus; each is scored against an arithmetic model of c*(1 + m*b).
module tb_am_modulator_pipe;
  localparam int unsigned DW = 12;
  localparam int unsigned MW = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic [DW-1:0] i_carrier;
  logic [DW-1:0] i_baseband;
  logic          i_valid;
  logic [MW-1:0] i_mod_index;
  logic          i_enable;
  logic          i_ready;
  logic [DW-1:0] am_j, am_r;
  logic          ov_j, ov_r, rdy_j, rdy_r, busy_j, busy_r;

  always #5 i_clk = ~i_clk;

  am_modulator_pipe #(.DW(DW), .MW(MW), .RAMP_STEP(16'h0000)) dut_j (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_carrier(i_carrier), .i_baseband(i_baseband),
    .i_valid(i_valid), .o_ready(rdy_j), .i_mod_index(i_mod_index), .i_enable(i_enable),
    .o_amSignal(am_j), .o_valid(ov_j), .i_ready(i_ready), .o_ramp_busy(busy_j));

  am_modulator_pipe #(.DW(DW), .MW(MW), .RAMP_STEP(16'h0100)) dut_r (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_carrier(i_carrier), .i_baseband(i_baseband),
    .i_valid(i_valid), .o_ready(rdy_r), .i_mod_index(i_mod_index), .i_enable(i_enable),
    .o_amSignal(am_r), .o_valid(ov_r), .i_ready(i_ready), .o_ramp_busy(busy_r));

  int            n_tests = 0;
  int            n_fail  = 0;
  int            m_j = 0;
  int            m_r = 0;
  int            n_xfer = 0;
  int            n_out = 0;
  logic [DW-1:0] q_j[$];
  logic [DW-1:0] q_r[$];
  logic [DW-1:0] last_j = '0, prev_j = '0, last_r = '0, prev_r = '0;

  typedef struct {
    logic [DW-1:0] c;
    logic [DW-1:0] b;
    logic [MW-1:0] m;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t vt[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // c*(1 + m*b) with m in Q1.15, b in Q1.11, c in Q2.10, result Q3.9.
  function automatic logic [DW-1:0] ref_am(input logic [DW-1:0] c, input logic [DW-1:0] b,
                                           input int m, input bit dis);
    longint cs, bs, s, o;
    if (dis) return 12'h7FF;
    cs = longint'($signed(c));
    bs = longint'($signed(b));
    s  = (longint'(m) * bs) >>> 15;
    if (s > 2047) s = 2047;
    if (s < -2048) s = -2048;
    o = (cs * (2048 + s) + 2048) >>> 12;
    if (o > 2047) o = 2047;
    if (o < -2048) o = -2048;
    return DW'(o);
  endfunction

  function automatic int ramp(input int cur, input int tgt, input int stp);
    if (stp == 0) return tgt;
    if (tgt > cur) return (tgt - cur > stp) ? cur + stp : tgt;
    return (cur - tgt > stp) ? cur - stp : tgt;
  endfunction

  // Called at a falling edge with inputs applied; returns at the next falling edge.
  task automatic step();
    int            tgt;
    logic [DW-1:0] e;
    #1;
    if (!i_rst_n) begin
      q_j.delete();
      q_r.delete();
      m_j = 0;
      m_r = 0;
      @(posedge i_clk);
      #1;
      check("rst_valid_j", 32'(ov_j), 32'd0);
      check("rst_valid_r", 32'(ov_r), 32'd0);
      check("rst_data_j", 32'(am_j), 32'd0);
      check("rst_data_r", 32'(am_r), 32'd0);
      check("rst_busy_j", 32'(busy_j), 32'd0);
      check("rst_busy_r", 32'(busy_r), 32'd0);
    end else begin
      if (ov_j && i_ready) begin
        if (q_j.size() == 0) check("unexpected_out_j", 32'(am_j), 32'hFFFF_FFFF);
        else begin
          e = q_j.pop_front();
          check("data_j", 32'(am_j), 32'(e));
          prev_j = last_j;
          last_j = am_j;
          n_out++;
        end
      end
      if (ov_r && i_ready) begin
        if (q_r.size() == 0) check("unexpected_out_r", 32'(am_r), 32'hFFFF_FFFF);
        else begin
          e = q_r.pop_front();
          check("data_r", 32'(am_r), 32'(e));
          prev_r = last_r;
          last_r = am_r;
        end
      end
      tgt = i_enable ? int'(i_mod_index) : 0;
      if (i_valid && rdy_j) begin
        q_j.push_back(ref_am(i_carrier, i_baseband, m_j, !i_enable && m_j == 0));
        q_r.push_back(ref_am(i_carrier, i_baseband, m_r, !i_enable && m_r == 0));
        m_j = ramp(m_j, tgt, 0);
        m_r = ramp(m_r, tgt, 256);
        n_xfer++;
      end
      @(posedge i_clk);
      #1;
      check("busy_j", 32'(busy_j), 32'(m_j != tgt));
      check("busy_r", 32'(busy_r), 32'(m_r != tgt));
    end
    @(negedge i_clk);
  endtask

  task automatic drain();
    i_valid = 1'b0;
    i_ready = 1'b1;
    repeat (6) step();
  endtask

  initial begin
    int cnt, base, out_base, cyc, px;
    logic [DW-1:0] snap_d;

    vt[0]  = '{12'h400, 12'h400, 16'h8000, 12'h300};
    vt[1]  = '{12'h400, 12'h5A5, 16'h0000, 12'h200};
    vt[2]  = '{12'h800, 12'h7FF, 16'h8000, 12'h801};
    vt[3]  = '{12'h400, 12'h600, 16'hC000, 12'h400};
    vt[4]  = '{12'h7FF, 12'h7FF, 16'hFFFF, 12'h7FF};
    vt[5]  = '{12'hC00, 12'h400, 16'h8000, 12'hD00};
    vt[6]  = '{12'h001, 12'h000, 16'h0000, 12'h001};
    vt[7]  = '{12'hFFF, 12'h000, 16'h0000, 12'h000};
    vt[8]  = '{12'h400, 12'hC00, 16'h8000, 12'h100};
    vt[9]  = '{12'h400, 12'h800, 16'h8000, 12'h000};
    vt[10] = '{12'h400, 12'h800, 16'hFFFF, 12'h000};

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1; i_enable = 1'b1;
    i_mod_index = '0; i_carrier = '0; i_baseband = '0;
    @(negedge i_clk);
    step();
    i_rst_n = 1'b1;

    // Vector table: a priming transfer loads the index, then a timed transfer.
    for (int k = 0; k < 11; k++) begin
      i_mod_index = vt[k].m; i_carrier = vt[k].c; i_baseband = vt[k].b;
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      repeat (3) step();
      i_valid = 1'b1;
      step();
      i_valid = 1'b0;
      check($sformatf("vec%0d_lat1", k), 32'(ov_j), 32'd0);
      step();
      check($sformatf("vec%0d_lat2", k), 32'(ov_j), 32'd0);
      step();
      check($sformatf("vec%0d_valid", k), 32'(ov_j), 32'd1);
      check($sformatf("vec%0d_data", k), 32'(am_j), 32'(vt[k].exp));
      step();
    end

    // Disable on the jump instance: first sample still modulated, then DIS_VALUE.
    i_enable = 1'b0; i_carrier = 12'h400; i_baseband = 12'h400; i_valid = 1'b1;
    repeat (2) step();
    drain();
    check("dis_first", 32'(prev_j), 32'h400);
    check("dis_value", 32'(last_j), 32'h7FF);

    // Backpressure: 10 samples with a 4-cycle downstream stall.
    i_enable = 1'b1; i_mod_index = 16'h8000;
    base = n_xfer; out_base = n_out; cyc = 0; snap_d = '0;
    i_valid = 1'b1; i_carrier = DW'($urandom); i_baseband = DW'($urandom);
    while (n_xfer - base < 10 && cyc < 60) begin
      i_ready = !(cyc >= 4 && cyc < 8);
      #1;
      if (!i_ready) check("bp_ready", 32'(rdy_j), 32'd0);
      if (cyc == 4) snap_d = am_j;
      if (cyc >= 5 && cyc <= 8) begin
        check("bp_hold_valid", 32'(ov_j), 32'd1);
        check("bp_hold_data", 32'(am_j), 32'(snap_d));
      end
      px = n_xfer;
      step();
      cyc++;
      if (n_xfer != px) begin
        i_carrier = DW'($urandom);
        i_baseband = DW'($urandom);
      end
    end
    drain();
    check("bp_count", 32'(n_out - out_base), 32'd10);
    check("bp_q_empty", 32'(q_j.size()), 32'd0);

    // Ramp up on the ramped instance from a fresh reset.
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1; i_enable = 1'b1; i_mod_index = 16'h8000;
    i_carrier = 12'h400; i_baseband = 12'h400; i_valid = 1'b0;
    step();
    cnt = 0;
    i_valid = 1'b1;
    repeat (128) begin
      if (busy_r) cnt++;
      step();
    end
    check("ramp_up_busy_cnt", 32'(cnt), 32'd128);
    check("ramp_up_done", 32'(busy_r), 32'd0);

    // Ramp down: the 129th sample after disable is the first DIS_VALUE.
    i_enable = 1'b0;
    repeat (129) step();
    drain();
    check("ramp_down_128", 32'(prev_r), 32'h202);
    check("ramp_down_129", 32'(last_r), 32'h7FF);
    check("ramp_down_idle", 32'(busy_r), 32'd0);

    // Reversal mid-ramp continues from the current index.
    i_enable = 1'b1; i_valid = 1'b1;
    repeat (32) step();
    i_enable = 1'b0;
    repeat (16) step();
    i_enable = 1'b1;
    cnt = 0;
    while (busy_r && cnt < 300) begin
      step();
      cnt++;
    end
    check("ramp_reverse_cnt", 32'(cnt), 32'd112);

    // Reset mid-stream and mid-ramp; first sample afterwards uses index 0.
    i_enable = 1'b0;
    repeat (20) step();
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1; i_enable = 1'b1; i_carrier = 12'h400; i_baseband = 12'h400;
    step();
    i_valid = 1'b0;
    check("post_rst_lat1", 32'(ov_r), 32'd0);
    step();
    step();
    check("post_rst_valid", 32'(ov_r), 32'd1);
    check("post_rst_data_r", 32'(am_r), 32'h200);
    check("post_rst_data_j", 32'(am_j), 32'h200);
    drain();

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      i_valid = ($urandom_range(0, 3) != 0);
      i_ready = ($urandom_range(0, 4) != 0);
      i_carrier = DW'($urandom);
      i_baseband = DW'($urandom);
      if ($urandom_range(0, 49) == 0) i_enable = ~i_enable;
      if ($urandom_range(0, 19) == 0) i_mod_index = MW'($urandom);
      step();
    end
    drain();
    check("final_q_empty_j", 32'(q_j.size()), 32'd0);
    check("final_q_empty_r", 32'(q_r.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
